// File: rtl/neuron_mac_unit_if.sv
// Read-side bus between the MAC unit and its input-vector / weight SRAMs.
// The MAC unit is the master: it issues strobes and addresses and consumes read data.
interface neuron_mac_unit_if #(
    parameter int num_bit    = 8,
    parameter int addr_width = 4
);
    logic                  x_read_enable;
    logic [addr_width-1:0] x_address;
    logic [num_bit-1:0]    x_read_data;
    logic                  w_read_enable;
    logic [addr_width-1:0] w_address;
    logic [num_bit-1:0]    w_read_data;

    modport master (
        output x_read_enable, x_address, w_read_enable, w_address,
        input  x_read_data, w_read_data
    );

    modport slave (
        input  x_read_enable, x_address, w_read_enable, w_address,
        output x_read_data, w_read_data
    );
endinterface

// File: rtl/neuron_mac_unit.sv
// Single-neuron MAC: y = ReLU(sum(x[i]*w[i]) + bias), saturated to num_bit signed.
// One operand pair is fetched and accumulated every two cycles.
module neuron_mac_unit #(
    parameter int num_bit    = 8,
    parameter int num_inputs = 4,
    parameter int addr_width = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic signed [num_bit-1:0] bias,
    neuron_mac_unit_if.master         mem,
    output logic                      busy,
    output logic signed [num_bit-1:0] result,
    output logic                      result_valid
);
    // Wide enough that num_inputs worst-case products plus bias never wrap.
    localparam int acc_w = 2*num_bit + $clog2(num_inputs) + 1;
    localparam logic signed [acc_w-1:0]   sat_max  = acc_w'(2**(num_bit-1) - 1);
    localparam logic [addr_width-1:0]     last_idx = addr_width'(num_inputs - 1);

    typedef enum logic [2:0] {IDLE, FETCH, MAC, BIAS, ACT, DONE} state_t;

    state_t                      state, state_next;
    logic [addr_width-1:0]       idx;
    logic signed [acc_w-1:0]     acc;
    logic signed [num_bit-1:0]   bias_q;
    logic signed [2*num_bit-1:0] product;

    assign product = $signed(mem.x_read_data) * $signed(mem.w_read_data);

    // idx only moves on the edge that enters FETCH, so it doubles as the held address.
    assign mem.x_address = idx;
    assign mem.w_address = idx;

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: default assignment first keeps this combinational block free of inferred latches.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = FETCH;
            FETCH:   state_next = MAC;
            MAC:     state_next = (idx == last_idx) ? BIAS : FETCH;
            BIAS:    state_next = ACT;
            ACT:     state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mem.x_read_enable = (state == FETCH);
        mem.w_read_enable = (state == FETCH);
        busy              = (state != IDLE);
        result_valid      = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx    <= '0;
            acc    <= '0;
            bias_q <= '0;
            result <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        acc    <= '0;
                        idx    <= '0;
                        bias_q <= bias;
                    end
                end
                MAC: begin
                    acc <= acc + acc_w'(product);
                    if (idx != last_idx) idx <= idx + 1'b1;
                end
                BIAS: acc <= acc + acc_w'(bias_q);
                ACT: begin
                    if (acc < 0)            result <= '0;
                    else if (acc > sat_max) result <= num_bit'(sat_max);
                    else                    result <= acc[num_bit-1:0];
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_neuron_mac_unit.sv
// Self-checking bench for neuron_mac_unit: behavioural SRAMs plus an integer dot-product model.
module tb_neuron_mac_unit;
    localparam int num_bit    = 8;
    localparam int num_inputs = 4;
    localparam int addr_width = 4;
    localparam int lat        = 2*num_inputs + 3;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      start;
    logic signed [num_bit-1:0] bias;
    logic                      busy;
    logic signed [num_bit-1:0] result;
    logic                      result_valid;

    neuron_mac_unit_if #(.num_bit(num_bit), .addr_width(addr_width)) mem_bus ();

    neuron_mac_unit #(
        .num_bit(num_bit), .num_inputs(num_inputs), .addr_width(addr_width)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .bias(bias), .mem(mem_bus),
        .busy(busy), .result(result), .result_valid(result_valid)
    );

    always #5 clk = ~clk;

    logic [num_bit-1:0] x_mem [16];
    logic [num_bit-1:0] w_mem [16];
    int xv [num_inputs];
    int wv [num_inputs];
    int checks = 0;
    int errors = 0;
    int held   = 0;

    // Synchronous-read SRAMs; garbage on the data bus when not strobed.
    always @(posedge clk) begin
        if (mem_bus.x_read_enable) mem_bus.x_read_data <= x_mem[mem_bus.x_address];
        else                       mem_bus.x_read_data <= num_bit'($urandom);
        if (mem_bus.w_read_enable) mem_bus.w_read_data <= w_mem[mem_bus.w_address];
        else                       mem_bus.w_read_data <= num_bit'($urandom);
    end

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int model(input int b);
        int s = b;
        for (int i = 0; i < num_inputs; i++) s += xv[i] * wv[i];
        if (s < 0)   return 0;
        if (s > 127) return 127;
        return s;
    endfunction

    task automatic load_mem();
        for (int i = 0; i < 16; i++) begin
            x_mem[i] = num_bit'($urandom);
            w_mem[i] = num_bit'($urandom);
        end
        for (int i = 0; i < num_inputs; i++) begin
            x_mem[i] = num_bit'(xv[i]);
            w_mem[i] = num_bit'(wv[i]);
        end
    endtask

    // One computation. restart_cyc pulses a stray start (bias 99); rst_cyc aborts with reset.
    task automatic run(input string tag, input int b, input int restart_cyc,
                       input int rst_cyc, input int tail);
        int exp_r, busy_cnt, valid_cnt, valid_cyc, got_r;
        int addr_x[$];
        int addr_w[$];
        busy_cnt  = 0;
        valid_cnt = 0;
        valid_cyc = -1;
        got_r     = -1;
        exp_r     = model(b);
        @(negedge clk);
        check({tag, "_held"}, result, held);
        start = 1'b1;
        bias  = num_bit'(b);
        for (int k = 1; k <= lat + tail; k++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (result_valid) begin
                valid_cnt++;
                valid_cyc = k;
                got_r     = int'(result);
            end
            if (mem_bus.x_read_enable) addr_x.push_back(int'(mem_bus.x_address));
            if (mem_bus.w_read_enable) addr_w.push_back(int'(mem_bus.w_address));
            start = (k == restart_cyc);
            if (k == restart_cyc) bias = 8'sd99;
            if (k == rst_cyc + 1) rst = 1'b0;
            if (k == rst_cyc) begin
                rst = 1'b1;
                #1;
                check({tag, "_rst_busy"}, busy, 0);
                check({tag, "_rst_xre"}, mem_bus.x_read_enable, 0);
                check({tag, "_rst_wre"}, mem_bus.w_read_enable, 0);
                check({tag, "_rst_xaddr"}, mem_bus.x_address, 0);
                check({tag, "_rst_waddr"}, mem_bus.w_address, 0);
                check({tag, "_rst_result"}, result, 0);
            end
        end
        if (rst_cyc > 0) begin
            check({tag, "_no_valid"}, valid_cnt, 0);
            held = 0;
        end else begin
            check({tag, "_valid_cnt"}, valid_cnt, 1);
            check({tag, "_valid_cyc"}, valid_cyc, lat);
            check({tag, "_busy_cnt"}, busy_cnt, lat);
            check({tag, "_result"}, got_r, exp_r);
            check({tag, "_naddr"}, addr_x.size(), num_inputs);
            check({tag, "_nwaddr"}, addr_w.size(), num_inputs);
            for (int i = 0; i < addr_x.size() && i < num_inputs; i++)
                check({tag, "_xaddr"}, addr_x[i], i);
            for (int i = 0; i < addr_w.size() && i < num_inputs; i++)
                check({tag, "_waddr"}, addr_w[i], i);
            held = exp_r;
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        bias  = '0;
        #1;
        check("reset_busy", busy, 0);
        check("reset_valid", result_valid, 0);
        check("reset_result", result, 0);
        check("reset_xre", mem_bus.x_read_enable, 0);
        check("reset_wre", mem_bus.w_read_enable, 0);
        check("reset_xaddr", mem_bus.x_address, 0);
        check("reset_waddr", mem_bus.w_address, 0);
        @(negedge clk);
        rst = 1'b0;

        xv = '{1, 2, 3, 4};
        wv = '{5, 6, 7, 8};
        load_mem();
        run("basic", -10, 0, 0, 3);

        xv = '{1, 1, 1, 1};
        wv = '{-5, -5, -5, -5};
        load_mem();
        run("relu", 3, 0, 0, 3);

        xv = '{-128, -128, -128, -128};
        wv = '{-128, -128, -128, -128};
        load_mem();
        run("sat", 127, 0, 0, 3);

        xv = '{1, 2, 3, 4};
        wv = '{5, 6, 7, 8};
        load_mem();
        run("busy_start", -10, 4, 0, 3);
        run("abort", -10, 0, 5, 3);
        run("fresh", -10, 0, 0, 0);
        run("b2b", 0, 0, 0, 3);
        run("done_start", -10, lat, 0, 3);

        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < num_inputs; i++) begin
                xv[i] = int'($urandom_range(0, 255)) - 128;
                wv[i] = int'($urandom_range(0, 255)) - 128;
            end
            load_mem();
            run("rand", int'($urandom_range(0, 255)) - 128, 0, 0, 2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
